// File: rtl/onehot_decoder_seq.sv
// onehot_decoder_seq: registered 3-to-8 one-hot decoder with dwell/gap sequencer and auto-scan
module onehot_decoder_seq #(
    parameter int DWELL = 4,
    parameter int GAP   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] D,
    input  logic       d_valid,
    output logic       d_ready,
    input  logic       scan,
    output logic [7:0] I,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_t;
    localparam logic [7:0] DW1 = 8'(DWELL - 1);
    localparam logic [7:0] GP1 = 8'(GAP - 1);
    state_t     r_state, w_state_nx;
    logic [7:0] r_cnt, w_cnt_nx;
    logic [7:0] r_i, w_i_nx;
    logic [2:0] r_idx, w_idx_nx;
    logic       r_started, w_started_nx;
    logic       r_busy;
    logic [2:0] w_idx_inc;
    logic [2:0] w_idx_first;
    assign w_idx_inc   = r_idx + 3'd1;
    // a fresh scan after reset starts at the stored index; a resumed scan continues past it
    assign w_idx_first = r_started ? w_idx_inc : r_idx;
    assign I           = r_i;
    assign busy        = r_busy;
    // state, counters, scan index and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_i       <= '0;
            r_idx     <= '0;
            r_started <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_i       <= w_i_nx;
            r_idx     <= w_idx_nx;
            r_started <= w_started_nx;
            r_busy    <= (w_state_nx != S_IDLE);
        end
    end
    // next-state, counter and next one-hot selection
    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_i_nx       = r_i;
        w_idx_nx     = r_idx;
        w_started_nx = r_started;
        case (r_state)
            S_IDLE: begin
                if (scan) begin
                    w_state_nx   = S_DRIVE;
                    w_cnt_nx     = DW1;
                    w_idx_nx     = w_idx_first;
                    w_started_nx = 1'b1;
                    w_i_nx       = 8'd1 << w_idx_first;
                end else if (d_valid) begin
                    w_state_nx = S_DRIVE;
                    w_cnt_nx   = DW1;
                    w_i_nx     = 8'd1 << D;
                end
            end
            S_DRIVE: begin
                if (r_cnt != 8'd0) begin
                    w_cnt_nx = r_cnt - 8'd1;
                end else if (GAP > 0) begin
                    w_state_nx = S_GAP;
                    w_cnt_nx   = GP1;
                    w_i_nx     = '0;
                end else if (scan) begin
                    w_cnt_nx     = DW1;
                    w_idx_nx     = w_idx_inc;
                    w_started_nx = 1'b1;
                    w_i_nx       = 8'd1 << w_idx_inc;
                end else begin
                    w_state_nx = S_IDLE;
                    w_i_nx     = '0;
                end
            end
            S_GAP: begin
                if (r_cnt != 8'd0) begin
                    w_cnt_nx = r_cnt - 8'd1;
                end else if (scan) begin
                    w_state_nx   = S_DRIVE;
                    w_cnt_nx     = DW1;
                    w_idx_nx     = w_idx_inc;
                    w_started_nx = 1'b1;
                    w_i_nx       = 8'd1 << w_idx_inc;
                end else begin
                    w_state_nx = S_IDLE;
                    w_i_nx     = '0;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_i_nx     = '0;
            end
        endcase
    end
    // handshake ready and last-dwell-cycle strobe
    always_comb begin
        d_ready = (r_state == S_IDLE) && !scan;
        done    = (r_state == S_DRIVE) && (r_cnt == 8'd0);
    end
endmodule

// File: tb/tb_onehot_decoder_seq.sv
// tb_onehot_decoder_seq: vector table, directed corner sequences and randomized model comparison
module tb_onehot_decoder_seq;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] D;
    logic       d_valid, scan;
    logic [7:0] a_i, b_i;
    logic       a_rdy, a_busy, a_done, b_rdy, b_busy, b_done;
    int checks = 0;
    int failures = 0;
    int sel = 0;
    int mdw = 4;
    int mgp = 1;
    bit m_active, m_started;
    int m_pos, m_code, m_idx;

    typedef struct {
        logic [2:0] d;
        logic       v;
        logic       s;
        logic [7:0] ei;
        logic       eb;
        logic       ed;
        logic       er;
    } vec_t;
    vec_t tbl[8];

    onehot_decoder_seq #(.DWELL(4), .GAP(1)) u_a (
        .clk(clk), .rst(rst), .D(D), .d_valid(d_valid), .d_ready(a_rdy),
        .scan(scan), .I(a_i), .busy(a_busy), .done(a_done)
    );
    onehot_decoder_seq #(.DWELL(1), .GAP(0)) u_b (
        .clk(clk), .rst(rst), .D(D), .d_valid(d_valid), .d_ready(b_rdy),
        .scan(scan), .I(b_i), .busy(b_busy), .done(b_done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] cur_i();
        return sel != 0 ? b_i : a_i;
    endfunction
    function automatic logic cur_busy();
        return sel != 0 ? b_busy : a_busy;
    endfunction
    function automatic logic cur_done();
        return sel != 0 ? b_done : a_done;
    endfunction
    function automatic logic cur_rdy();
        return sel != 0 ? b_rdy : a_rdy;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a code occupies DWELL drive cycles followed by GAP zero cycles,
    // measured as a position since the code started.
    task automatic model_reset();
        m_active = 0; m_started = 0; m_pos = 0; m_code = 0; m_idx = 0;
    endtask

    task automatic model_step();
        if (m_active) begin
            if (m_pos == mdw + mgp - 1) begin
                if (scan) begin
                    m_idx = (m_idx + 1) % 8; m_started = 1; m_code = m_idx; m_pos = 0;
                end else begin
                    m_active = 0;
                end
            end else begin
                m_pos++;
            end
        end else if (scan) begin
            if (m_started) m_idx = (m_idx + 1) % 8;
            m_started = 1; m_code = m_idx; m_active = 1; m_pos = 0;
        end else if (d_valid) begin
            m_code = int'(D); m_active = 1; m_pos = 0;
        end
    endtask

    task automatic check_all();
        logic [7:0] ei;
        ei = (m_active && m_pos < mdw) ? 8'(1 << m_code) : 8'h00;
        chk("I", cur_i(), ei);
        chk("busy", 8'(cur_busy()), 8'(m_active));
        chk("done", 8'(cur_done()), 8'(m_active && m_pos == mdw - 1));
        chk("d_ready", 8'(cur_rdy()), 8'(!m_active && !scan));
    endtask

    task automatic cyc(input logic [2:0] d, input logic v, input logic s);
        D = d; d_valid = v; scan = s;
        #1 check_all();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset(input int s);
        sel = s;
        mdw = (s != 0) ? 1 : 4;
        mgp = (s != 0) ? 0 : 1;
        rst = 1'b1; D = '0; d_valid = 1'b0; scan = 1'b0;
        model_reset();
        #1 check_all();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_until(input logic [7:0] target, input logic [2:0] d, input logic v,
                             input logic s, input int budget);
        int n;
        n = 0;
        while (cur_i() !== target && n < budget) begin
            cyc(d, v, s);
            n++;
        end
        chk("wait_for_I", cur_i(), target);
    endtask

    initial begin
        int e, n;
        logic s;
        tbl[0] = '{3'd5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{3'd0, 1'b0, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{3'd0, 1'b0, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{3'd0, 1'b0, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{3'd0, 1'b0, 1'b0, 8'h20, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{3'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{3'd2, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{3'd0, 1'b0, 1'b0, 8'h04, 1'b1, 1'b0, 1'b0};
        rst = 1'b1; D = '0; d_valid = 1'b0; scan = 1'b0;
        @(negedge clk);

        do_reset(0);
        for (int k = 0; k < 8; k++) begin
            D = tbl[k].d; d_valid = tbl[k].v; scan = tbl[k].s;
            #1;
            chk($sformatf("tbl%0d_I", k), a_i, tbl[k].ei);
            chk($sformatf("tbl%0d_busy", k), 8'(a_busy), 8'(tbl[k].eb));
            chk($sformatf("tbl%0d_done", k), 8'(a_done), 8'(tbl[k].ed));
            chk($sformatf("tbl%0d_rdy", k), 8'(a_rdy), 8'(tbl[k].er));
            @(posedge clk);
            model_step();
            @(negedge clk);
        end
        for (int k = 0; k < 6; k++) cyc(3'd0, 1'b0, 1'b0);

        do_reset(0);
        for (int d = 0; d < 8; d++) begin
            n = 0;
            while (!cur_rdy() && n < 20) begin
                cyc(3'(d), 1'b1, 1'b0);
                n++;
            end
            cyc(3'(d), 1'b1, 1'b0);
            chk("decode", cur_i(), 8'(1 << d));
            e = -1;
            for (int b = 0; b < 8; b++) if (a_i[b]) e = b;
            chk("encode_back", 8'(e), 8'(d));
        end
        for (int k = 0; k < 6; k++) cyc(3'd0, 1'b0, 1'b0);

        do_reset(0);
        for (int k = 0; k < 45; k++) cyc(3'd0, 1'b0, 1'b1);

        do_reset(0);
        run_until(8'h08, 3'd0, 1'b0, 1'b1, 40);
        for (int k = 0; k < 6; k++) cyc(3'd0, 1'b0, 1'b0);
        cyc(3'd0, 1'b0, 1'b1);
        chk("scan_resume", a_i, 8'h10);
        for (int k = 0; k < 6; k++) cyc(3'd0, 1'b0, 1'b0);

        do_reset(0);
        cyc(3'd6, 1'b1, 1'b0);
        run_until(8'h04, 3'd2, 1'b1, 1'b0, 20);
        for (int k = 0; k < 6; k++) cyc(3'd0, 1'b0, 1'b0);

        do_reset(0);
        cyc(3'd7, 1'b1, 1'b1);
        chk("scan_priority", a_i, 8'h01);

        do_reset(0);
        run_until(8'h40, 3'd0, 1'b0, 1'b1, 60);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_I", a_i, 8'h00);
        chk("async_rst_busy", 8'(a_busy), 8'h00);
        chk("rst_rdy_scan", 8'(a_rdy), 8'h00);
        model_reset();
        scan = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst_rdy", 8'(a_rdy), 8'h01);
        cyc(3'd0, 1'b0, 1'b1);
        chk("scan_restart", a_i, 8'h01);

        do_reset(1);
        for (int k = 0; k < 20; k++) cyc(3'd0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) cyc(3'd0, 1'b0, 1'b0);

        for (int p = 0; p < 2; p++) begin
            do_reset(p);
            s = 1'b0;
            for (int k = 0; k < 400; k++) begin
                if ($urandom_range(0, 19) == 0) s = ~s;
                cyc(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), s);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/onehot_decoder_seq.md
Name: onehot_decoder_seq

Overview:
- Registered 3-to-8 one-hot decoder with a sequencer. It is the inverse of the team's 8-to-3 one-hot encoder.
- Accepts 3-bit codes over a valid/ready handshake. Drives the matching one-hot line for a programmable dwell time, then a programmable idle gap.
- An auto-scan mode walks codes 0..7 continuously. Intended use: line/strobe driver feeding encoder-side logic and benches.

Parameters:
- DWELL, 4, cycles each one-hot output is held (legal range 1..255)
- GAP, 1, cycles of all-zero output after each dwell (legal range 0..255)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- D  input  3  binary code to decode
- d_valid  input  1  D is valid
- d_ready  output  1  block can accept a code this cycle
- scan  input  1  auto-scan mode request
- I  output  8  registered one-hot output; all-zero when not driving
- busy  output  1  high in DRIVE or GAP
- done  output  1  one-cycle pulse on the last DWELL cycle of each code

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, I=8'h00, busy=0, done=0, scan index=0, counters=0.
  - rst asserted mid-operation clears I immediately (no clock edge needed) and abandons the current code.
- States: IDLE, DRIVE, GAP.
- d_ready: combinational, equal to (state==IDLE) && !scan. During reset it reads !scan.
- IDLE:
  - If scan=1: load code = scan index, I <= 1<<index, go to DRIVE. d_valid is ignored; scan has priority.
  - Else if d_valid && d_ready at an edge: I <= 1<<D, go to DRIVE.
  - Code latency: handshake at edge k, so I is valid from cycle k+1.
  - D must stay stable while d_valid=1 and d_ready=0. The accepted code is D at the handshake edge.
- DRIVE:
  - I holds 1<<code for exactly DWELL cycles; dwell counter loads DWELL-1 and decrements.
  - done=1 during the final DWELL cycle only.
  - At the end of dwell:
    - GAP>0: I <= 0, go to GAP.
    - GAP=0 and scan still 1: start the next scan code directly.
    - GAP=0 and scan=0: I <= 0, go to IDLE.
- GAP:
  - I=0 for exactly GAP cycles.
  - At the end: if scan=1, index <= index+1 (wraps 7->0) and go to DRIVE with the new one-hot; else go to IDLE.
- Throughput:
  - Handshake mode: one code per DWELL+GAP+1 cycles (one IDLE cycle between codes).
  - Scan mode: period DWELL+GAP, no IDLE cycle.
- Scan index rules:
  - Advances only when moving to the next scan code.
  - Deasserting scan mid-code finishes the current DRIVE and GAP, then returns to IDLE. The index is retained, so the next scan resumes at index+1.
  - With GAP=0, the same increment rule applies at the DRIVE-to-DRIVE transition.
- Output and width rules:
  - I is only ever 8'h00 or exactly one bit set. No X/Z output (unlike the encoder's default case).
  - busy = (state != IDLE), registered.
- Simultaneous events: d_valid arriving while busy is not accepted (d_ready=0); the requester holds it.

Test Plan:
- Basic decode (DWELL=4, GAP=1): reset, then D=3'd5 with d_valid for one cycle at handshake edge k.
  - I=8'b0010_0000 in cycles k+1..k+4; done=1 only in k+4; I=0 in k+5; d_ready=1 again from k+6.
- Exhaustive decode: D=0..7 sequentially, each held until accepted -> I = 01,02,04,08,10,20,40,80. Feeding I into the encoder returns the original D.
- Scan (DWELL=4, GAP=1): scan=1 for 45 cycles.
  - I sequence 01..80, each held 4 cycles with a 1-cycle zero gap (period 5), wrapping 80 -> 01. d_ready stays 0 throughout.
- Scan drop: deassert scan during the DRIVE of code 3.
  - I=8'h08 completes 4 cycles, 1 gap cycle, then IDLE.
  - Re-assert scan -> next output is 8'h10.
- Backpressure and priority:
  - d_valid=1 with D=2 while busy -> not accepted until IDLE, then I=8'h04.
  - In IDLE with scan=1 and d_valid=1 together -> scan code is taken and D is not accepted.
- Reset mid-DRIVE: rst pulse between clock edges while I=8'h40 -> I=0 and busy=0 immediately. After release, d_ready=1 and the scan index restarts at 0.
- Parameter corner (DWELL=1, GAP=0): scan -> I changes every cycle 01,02,...,80,01 and done is high every cycle.
